// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: one wait-state memory transaction per MEM-stage load/store,
// with legality checks, byte-lane alignment, load extension and an ack timeout.
module dmem_access_ctrl #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [1:0]  whb,
    input  logic        su,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        cs_d_n,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    // state  | meaning
    // IDLE   | waiting for a request; legality checked here
    // ACCESS | memory strobed, waiting for mem_ack or timeout
    // RESP   | done pulse, err reflects the captured flag
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        is_rd_q, is_rd_d;
    logic        su_q, su_d;
    logic [1:0]  lane_q, lane_d;
    logic [1:0]  whb_q, whb_d;
    logic [29:0] addr_q, addr_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;

    logic        legal;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_c;

    always_comb begin
        legal   = ~(req_rd & req_wr);
        be_c    = 4'b1111;
        wdata_c = wdata;
        case (whb)
            2'b00: begin
                be_c    = 4'b0001 << addr[1:0];
                wdata_c = {4{wdata[7:0]}};
            end
            2'b01: begin
                if (addr[0]) legal = 1'b0;
                be_c    = 4'b0011 << {addr[1], 1'b0};
                wdata_c = {2{wdata[15:0]}};
            end
            2'b10: if (addr[1:0] != 2'b00) legal = 1'b0;
            default: legal = 1'b0;
        endcase
    end

    // Lane selection uses the registered low address bits, not the live request.
    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (lane_q)
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            2'd3:    byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (whb_q)
            2'b00:   load_c = {{24{~su_q & byte_sel[7]}}, byte_sel};
            2'b01:   load_c = {{16{~su_q & half_sel[15]}}, half_sel};
            default: load_c = mem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        is_rd_d = is_rd_q;
        su_d    = su_q;
        lane_d  = lane_q;
        whb_d   = whb_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (req_rd | req_wr) begin
                    if (legal) begin
                        state_d = ACCESS;
                        err_d   = 1'b0;
                        is_rd_d = req_rd;
                        su_d    = su;
                        lane_d  = addr[1:0];
                        whb_d   = whb;
                        addr_d  = addr[31:2];
                        be_d    = be_c;
                        wdata_d = wdata_c;
                    end else begin
                        state_d = RESP;
                        err_d   = 1'b1;
                    end
                end
            end
            ACCESS: begin
                cnt_d = cnt_q + 8'd1;
                if (mem_ack) begin
                    state_d = RESP;
                    err_d   = 1'b0;
                    if (is_rd_q) rdata_d = load_c;
                end else if (cnt_q == 8'(TIMEOUT - 1)) begin
                    state_d = RESP;
                    err_d   = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            err_q   <= 1'b0;
            is_rd_q <= 1'b0;
            su_q    <= 1'b0;
            lane_q  <= 2'd0;
            whb_q   <= 2'd0;
            addr_q  <= 30'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            is_rd_q <= is_rd_d;
            su_q    <= su_d;
            lane_q  <= lane_d;
            whb_q   <= whb_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    assign cs_d_n    = (state_q != ACCESS);
    assign mem_rd    = (state_q == ACCESS) & is_rd_q;
    assign mem_wr    = (state_q == ACCESS) & ~is_rd_q;
    assign mem_addr  = {addr_q, 2'b00};
    assign mem_be    = be_q;
    assign mem_wdata = wdata_q;
    assign done      = (state_q == RESP);
    assign err       = (state_q == RESP) & err_q;
    assign rdata     = rdata_q;
    assign stall     = (req_rd | req_wr) & ~done;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: transaction-timeline model checked every cycle, plus literal pins.
module tb_dmem_access_ctrl;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_rd = 1'b0, req_wr = 1'b0, su = 1'b0, mem_ack = 1'b0;
    logic [31:0] addr = '0, wdata = '0, mem_rdata = '0;
    logic [1:0]  whb = '0;
    logic        stall, done, err, cs_d_n, mem_rd, mem_wr;
    logic [31:0] rdata, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    dmem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .addr(addr), .wdata(wdata),
        .whb(whb), .su(su), .stall(stall), .done(done), .rdata(rdata), .err(err),
        .cs_d_n(cs_d_n), .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
        end
    endtask

    // Expected outputs for the current cycle, set by the driver after each rising edge.
    bit          exp_valid = 0, exp_acc = 0;
    logic        exp_cs_n, exp_rd, exp_wr, exp_stall, exp_done, exp_err;
    logic [31:0] exp_addr, exp_wd, exp_rdata;
    logic [3:0]  exp_be;
    logic [31:0] model_rdata = 32'd0;

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("cs_d_n", {31'd0, cs_d_n}, {31'd0, exp_cs_n});
            chk("mem_rd", {31'd0, mem_rd}, {31'd0, exp_rd});
            chk("mem_wr", {31'd0, mem_wr}, {31'd0, exp_wr});
            chk("stall", {31'd0, stall}, {31'd0, exp_stall});
            chk("done", {31'd0, done}, {31'd0, exp_done});
            chk("err", {31'd0, err}, {31'd0, exp_err});
            chk("rdata", rdata, exp_rdata);
            if (exp_acc) begin
                chk("mem_addr", mem_addr, exp_addr);
                chk("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
                chk("mem_wdata", mem_wdata, exp_wd);
            end
        end
    end

    function automatic logic [31:0] ld_model(logic [31:0] d, logic [31:0] a, logic [1:0] w, bit s);
        int nb;
        logic [31:0] v, m;
        nb = 1 << w;
        if (nb == 4) return d;
        m = (32'h1 << (8 * nb)) - 32'h1;
        v = (d >> (8 * (a % 4))) & m;
        if (!s && v[8*nb-1]) v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] st_model(logic [31:0] wd, logic [1:0] w);
        int nb;
        logic [31:0] r;
        nb = 1 << w;
        r = '0;
        for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % nb) +: 8];
        return r;
    endfunction

    function automatic logic [3:0] be_model(logic [31:0] a, logic [1:0] w);
        logic [7:0] t;
        t = 8'(((1 << (1 << w)) - 1) << (a % 4));
        return t[3:0];
    endfunction

    int          obs_done_k, obs_stall_n, obs_cs_n;
    logic        obs_err;
    logic [3:0]  obs_be;
    logic [31:0] obs_addr, obs_wd;

    task automatic set_idle_exp();
        exp_cs_n = 1; exp_rd = 0; exp_wr = 0; exp_stall = 0; exp_done = 0; exp_err = 0;
        exp_acc = 0; exp_rdata = model_rdata; exp_valid = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            req_rd = 0; req_wr = 0; mem_ack = 1'($urandom_range(0, 1)); mem_rdata = $urandom;
            set_idle_exp();
            @(negedge clk);
        end
    endtask

    // lat = wait states before ack; lat >= TIMEOUT means the ack never lands in ACCESS.
    task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                           input logic [1:0] w, input bit s, input int lat, input logic [31:0] rdat);
        bit legal, e, in_acc, ack;
        int n_acc, d_cyc, ack_cyc;
        legal = !(rd && wr) && (w != 2'b11) && ((a % (1 << w)) == 0);
        ack_cyc = lat + 1;
        if (!legal) begin n_acc = 0; e = 1; end
        else if (ack_cyc <= TIMEOUT) begin n_acc = ack_cyc; e = 0; end
        else begin n_acc = TIMEOUT; e = 1; end
        d_cyc = n_acc + 1;
        obs_done_k = -1; obs_stall_n = 0; obs_cs_n = 0; obs_err = 0;
        obs_be = 'x; obs_addr = 'x; obs_wd = 'x;
        for (int k = 0; k <= d_cyc; k++) begin
            @(posedge clk); #1;
            in_acc = legal && k >= 1 && k <= n_acc;
            ack = legal && k == ack_cyc;
            req_rd = rd; req_wr = wr; addr = a; wdata = wd; whb = w; su = s;
            mem_ack = ack ? 1'b1 : ((k == 0 || k == d_cyc) ? 1'($urandom_range(0, 1)) : 1'b0);
            mem_rdata = ack ? rdat : $urandom;
            if (k == d_cyc && legal && !e && rd) model_rdata = ld_model(rdat, a, w, s);
            exp_cs_n = !in_acc; exp_rd = in_acc && rd; exp_wr = in_acc && wr;
            exp_stall = k < d_cyc; exp_done = k == d_cyc; exp_err = (k == d_cyc) && e;
            exp_acc = in_acc; exp_addr = {a[31:2], 2'b00}; exp_be = be_model(a, w);
            exp_wd = st_model(wd, w); exp_rdata = model_rdata; exp_valid = 1;
            @(negedge clk);
            if (k == 1 && in_acc) begin obs_be = mem_be; obs_addr = mem_addr; obs_wd = mem_wdata; end
            if (done && obs_done_k < 0) begin obs_done_k = k; obs_err = err; end
            obs_stall_n += int'(stall);
            obs_cs_n += int'(!cs_d_n);
        end
        idle(1);
    endtask

    task automatic reset_mid();
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            req_rd = 1; req_wr = 0; addr = 32'h300; whb = 2'b10; su = 0; mem_ack = 0;
            exp_cs_n = (k == 0); exp_rd = (k != 0); exp_wr = 0; exp_stall = 1;
            exp_done = 0; exp_err = 0; exp_acc = (k != 0); exp_addr = 32'h300;
            exp_be = 4'hF; exp_wd = 32'h0; exp_rdata = model_rdata; exp_valid = (k == 0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        exp_valid = 0; rst = 1; req_rd = 0; #1;
        chk("rst_cs_d_n", {31'd0, cs_d_n}, 32'd1);
        chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        model_rdata = 32'd0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_no_done", {31'd0, done}, 32'd0);
            chk("rst_no_err", {31'd0, err}, 32'd0);
        end
        rst = 0;
        idle(1);
    endtask

    initial begin
        #2;
        chk("reset_cs_d_n", {31'd0, cs_d_n}, 32'd1);
        chk("reset_strobes", {30'd0, mem_rd, mem_wr}, 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        chk("reset_outs", {29'd0, stall, done, err}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
        @(negedge clk); @(negedge clk);
        rst = 0;
        idle(1);

        run_txn(1, 0, 32'h100, 32'h0, 2'b10, 0, 0, 32'hDEADBEEF);
        chk("t1_done_k", obs_done_k, 2);
        chk("t1_rdata", rdata, 32'hDEADBEEF);
        chk("t1_be", {28'd0, obs_be}, 32'hF);
        chk("t1_err", {31'd0, obs_err}, 0);

        run_txn(1, 0, 32'h103, 32'h0, 2'b00, 0, 1, 32'h80FFFFFF);
        chk("t2_sext", rdata, 32'hFFFFFF80);
        chk("t2_be", {28'd0, obs_be}, 32'h8);
        run_txn(1, 0, 32'h103, 32'h0, 2'b00, 1, 0, 32'h80FFFFFF);
        chk("t2_zext", rdata, 32'h00000080);

        run_txn(0, 1, 32'h202, 32'h1234ABCD, 2'b01, 0, 3, 32'h0);
        chk("t3_addr", obs_addr, 32'h200);
        chk("t3_be", {28'd0, obs_be}, 32'hC);
        chk("t3_wdata", obs_wd, 32'hABCDABCD);
        chk("t3_stall_n", obs_stall_n, 5);
        chk("t3_done_k", obs_done_k, 5);
        chk("t3_rdata_kept", rdata, 32'h00000080);

        run_txn(1, 0, 32'h101, 32'h0, 2'b10, 0, 0, 32'h0);
        chk("t4a_done_k", obs_done_k, 1);
        chk("t4a_err", {31'd0, obs_err}, 1);
        chk("t4a_no_cs", obs_cs_n, 0);
        run_txn(1, 0, 32'h100, 32'h0, 2'b11, 0, 0, 32'h0);
        chk("t4b_done_k", obs_done_k, 1);
        chk("t4b_err", {31'd0, obs_err}, 1);

        run_txn(1, 0, 32'h104, 32'h0, 2'b10, 0, 100, 32'h0);
        chk("t5a_done_k", obs_done_k, 17);
        chk("t5a_err", {31'd0, obs_err}, 1);
        run_txn(1, 0, 32'h108, 32'h0, 2'b10, 0, 15, 32'h13572468);
        chk("t5b_done_k", obs_done_k, 17);
        chk("t5b_err", {31'd0, obs_err}, 0);
        chk("t5b_rdata", rdata, 32'h13572468);

        reset_mid();
        run_txn(1, 0, 32'h10C, 32'h0, 2'b01, 0, 2, 32'hC0DE8001);
        chk("t6_after_rst", rdata, 32'hFFFF8001);

        for (int t = 0; t < 250; t++) begin
            bit rd, wr;
            logic [1:0] w;
            logic [31:0] a;
            int lat;
            rd = 1'($urandom_range(0, 1));
            wr = !rd;
            if ($urandom_range(0, 15) == 0) begin rd = 1; wr = 1; end
            w = 2'($urandom_range(0, 3));
            a = $urandom;
            if ($urandom_range(0, 9) < 7) a = a & ~((32'h1 << w) - 32'h1);
            lat = ($urandom_range(0, 7) == 0) ? $urandom_range(13, 18) : $urandom_range(0, 4);
            run_txn(rd, wr, a, $urandom, w, 1'($urandom_range(0, 1)), lat, $urandom);
            idle($urandom_range(0, 2));
        end

        exp_valid = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
